// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 8N1 serial receiver that deserialises rx into words and counts them against word_number.
// Latency: ready is registered one clk after the mid-stop sample edge (sample reg + output reg).
// Backpressure: none; words are pulsed out and must be taken in the ready cycle.
// Optional feature macro: UART_FRAME_RX_PARITY_EN adds an even-parity bit and a parity_error output.
module uart_frame_rx #(
    parameter int WORD_WIDTH   = 8,
    parameter int WN_BITS      = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  rx_enable,
    input  logic [WN_BITS-1:0]    word_number,
    output logic                  uart_master_write_ready,
    output logic [WORD_WIDTH-1:0] uart_master_data,
    output logic                  uart_master_write_stop,
`ifdef UART_FRAME_RX_PARITY_EN
    output logic                  parity_error,
`endif
    output logic                  frame_error
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(WORD_WIDTH);

    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(WORD_WIDTH - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;
`ifdef UART_FRAME_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd5;
    logic                  par_q;
`endif

    logic                  rx_meta;
    logic                  rx_s;
    logic [2:0]            state;
    logic [TW-1:0]         tmr;
    logic [IW-1:0]         bit_idx;
    logic [WORD_WIDTH-1:0] shift_q;
    logic                  done_q;
    logic                  stop_ok_q;
    logic [WN_BITS-1:0]    cnt;
    logic [WN_BITS-1:0]    cnt_next;
    logic [WN_BITS-1:0]    wn_q;

    assign cnt_next = cnt + 1'b1;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM: bit timing, data shifting and mid-stop sampling.
    always_ff @(posedge clk) begin
        if (reset || !rx_enable) begin
            state   <= S_IDLE;
            tmr     <= '0;
            bit_idx <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            tmr    <= tmr + 1'b1;
            case (state)
                S_IDLE: begin
                    tmr <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (tmr == T_HALF) begin
                        tmr     <= '0;
                        bit_idx <= '0;
                        // A start bit that is gone by mid-bit was a glitch.
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (tmr == T_FULL) begin
                        tmr     <= '0;
                        shift_q <= {rx_s, shift_q[WORD_WIDTH-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == I_LAST) begin
`ifdef UART_FRAME_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_FRAME_RX_PARITY_EN
                S_PARITY: begin
                    if (tmr == T_FULL) begin
                        tmr   <= '0;
                        par_q <= rx_s;
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tmr == T_FULL) begin
                        tmr       <= '0;
                        done_q    <= 1'b1;
                        stop_ok_q <= rx_s;
                        // Going straight to IDLE lets a back-to-back start bit be caught.
                        state     <= rx_s ? S_IDLE : S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    tmr <= '0;
                    if (rx_s) state <= S_IDLE;
                end
                default: begin
                    tmr   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output register: word delivery, transfer word counting and error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_master_write_ready <= 1'b0;
            uart_master_write_stop  <= 1'b0;
            uart_master_data        <= '0;
            frame_error             <= 1'b0;
            cnt                     <= '0;
            wn_q                    <= '0;
`ifdef UART_FRAME_RX_PARITY_EN
            parity_error            <= 1'b0;
`endif
        end else begin
            uart_master_write_ready <= 1'b0;
            uart_master_write_stop  <= 1'b0;
            frame_error             <= 1'b0;
`ifdef UART_FRAME_RX_PARITY_EN
            parity_error            <= 1'b0;
`endif
            if (!rx_enable) begin
                cnt <= '0;
            end else begin
                // Transfer length is captured only as the first frame of a transfer starts.
                if (state == S_IDLE && !rx_s && cnt == '0) wn_q <= word_number;
                if (done_q) begin
                    if (stop_ok_q) begin
                        uart_master_write_ready <= 1'b1;
                        uart_master_data        <= shift_q;
`ifdef UART_FRAME_RX_PARITY_EN
                        parity_error            <= (^shift_q) ^ par_q;
`endif
                        if (wn_q != '0 && cnt_next == wn_q) begin
                            uart_master_write_stop <= 1'b1;
                            cnt                    <= '0;
                        end else begin
                            cnt <= cnt_next;
                        end
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
module tb_uart_frame_rx;
    localparam int CPB = 16;
    localparam int W   = 8;
`ifdef UART_FRAME_RX_PARITY_EN
    localparam int NP  = 1;
`else
    localparam int NP  = 0;
`endif
    // start detect (2 sync + 1 idle) + half start bit + data/parity/stop bits + output reg
    localparam int LAT = 3 + CPB / 2 + (W + 1 + NP) * CPB + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx = 1'b1;
    logic         rx_enable = 1'b0;
    logic [3:0]   word_number = 4'd0;
    logic         ready;
    logic [W-1:0] data;
    logic         stop;
    logic         ferr;
`ifdef UART_FRAME_RX_PARITY_EN
    logic         perr;
`endif

    always #5 clk = ~clk;

    uart_frame_rx #(.WORD_WIDTH(W), .WN_BITS(4), .CLKS_PER_BIT(CPB)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .rx                      (rx),
        .rx_enable               (rx_enable),
        .word_number             (word_number),
        .uart_master_write_ready (ready),
        .uart_master_data        (data),
        .uart_master_write_stop  (stop),
`ifdef UART_FRAME_RX_PARITY_EN
        .parity_error            (perr),
`endif
        .frame_error             (ferr)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         s;
        logic         p;
        int           when;
    } exp_t;

    exp_t       sb[$];
    exp_t       got_e;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         ready_cnt = 0;
    int         ferr_cnt = 0;
    int         exp_ferr = 0;
    int         pushed = 0;
    logic [W-1:0] last_good = '0;
    logic [3:0] mcnt = 4'd0;
    logic [3:0] mwn = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Drives one frame and pushes the expected word (with model of the transfer counter).
    task automatic send_frame(input logic [W-1:0] d, input logic stop_bit, input logic par);
        exp_t e;
        if (mcnt == 4'd0) mwn = word_number;
        if (stop_bit) begin
            mcnt   = mcnt + 4'd1;
            e.d    = d;
            e.p    = (^d) ^ par;
            e.s    = 1'b0;
            if (mwn != 4'd0 && mcnt == mwn) begin
                e.s  = 1'b1;
                mcnt = 4'd0;
            end
            e.when = cyc + LAT;
            sb.push_back(e);
            pushed++;
        end else begin
            exp_ferr++;
        end
        drive_bit(1'b0);
        for (int i = 0; i < W; i++) drive_bit(d[i]);
`ifdef UART_FRAME_RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    // Output monitor: pops the scoreboard on every ready pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (ready) begin
                ready_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    got_e = sb.pop_front();
                    check("data", data, got_e.d);
                    check("stop", stop, got_e.s);
                    check("latency", cyc, got_e.when);
`ifdef UART_FRAME_RX_PARITY_EN
                    check("parity_err", perr, got_e.p);
`endif
                    last_good = got_e.d;
                end
            end else if (stop) begin
                check("stop_without_ready", 1, 0);
            end
            if (ferr) begin
                ferr_cnt++;
                check("ferr_no_ready", ready, 0);
                check("ferr_keeps_data", data, last_good);
            end
        end
    end

    initial begin
        logic [W-1:0] pat;
        // 1: reset with rx toggling
        repeat (3) begin
            @(negedge clk);
            rx = ~rx;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", ready, 0);
            check("rst_stop", stop, 0);
            check("rst_ferr", ferr, 0);
            check("rst_data", data, 0);
            rx = ~rx;
        end
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rx_enable = 1'b1;
        repeat (4) @(negedge clk);

        // 2: two-word transfer
        word_number = 4'd2;
        send_frame(8'hA5, 1'b1, ^8'hA5);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        repeat (2 * CPB) @(negedge clk);

        // 3: glitch on the line
        word_number = 4'd0;
        if (mcnt == 4'd0) mwn = word_number;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);

        // 4: bad stop bit, then a good frame
        send_frame(8'h55, 1'b0, ^8'h55);
        repeat (2 * CPB) @(negedge clk);
        send_frame(8'h81, 1'b1, ^8'h81);
        repeat (CPB) @(negedge clk);

        // 5: unbounded transfer, back-to-back frames, counter wraps
        for (int i = 0; i < 18; i++) begin
            pat = 8'(i * 37 + 11);
            send_frame(pat, 1'b1, ^pat);
        end
        repeat (2 * CPB) @(negedge clk);

        // 6: drop enable mid-frame, then single-word transfer
        drive_bit(1'b0);
        repeat (3) drive_bit(1'b1);
        rx_enable = 1'b0;
        mcnt = 4'd0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        word_number = 4'd1;
        repeat (6 * CPB) @(negedge clk);
        rx_enable = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h12, 1'b1, ^8'h12);
        repeat (2 * CPB) @(negedge clk);
`ifdef UART_FRAME_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (2 * CPB) @(negedge clk);
`endif

        // reset mid-frame clears data
        drive_bit(1'b0);
        repeat (4) drive_bit(1'b0);
        reset = 1'b1;
        mcnt = 4'd0;
        repeat (2) @(negedge clk);
        check("midrst_data", data, 0);
        check("midrst_ready", ready, 0);
        rx = 1'b1;
        reset = 1'b0;
        repeat (12 * CPB) @(negedge clk);

        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("ready_count", ready_cnt, pushed);
        check("ferr_count", ferr_cnt, exp_ferr);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
